mux_scan_nto1: RTL and testbench
================================

Name: mux_scan_nto1

Overview:
Parametrised, registered N-to-1 multiplexer; successor to the combinational 8-to-1 mux. It adds configurable channel count and data width, plus an output register with a valid/ready handshake. A manual-select mode and an auto-scan mode round-robin across enabled channels with a programmable dwell time. It sits between a bank of sampled sources and a single downstream consumer (e.g. a serialiser or logger).

Parameters:
WIDTH, 8, data width per channel in bits (>=1)
CHANNELS, 8, number of input channels (>=2)
SEL_W, $clog2(CHANNELS), select/channel-index width (derived; do not override)
DWELL, 4, cycles spent on each channel in scan mode before sampling (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = manual select, 1 = auto-scan
sel  input  SEL_W  manual channel select
ch_en  input  CHANNELS  per-channel enable mask; used in scan mode only
din  input  CHANNELS*WIDTH  packed inputs; channel k = din[k*WIDTH +: WIDTH]
out_data  output  WIDTH  registered selected sample
out_ch  output  SEL_W  channel index that out_data came from
out_valid  output  1  out_data/out_ch hold a sample
out_ready  input  1  consumer accepts the sample when out_valid & out_ready

Behaviour:
- Reset (async assert, sync release): out_data=0, out_ch=0, out_valid=0, scan pointer ptr=0, dwell counter cnt=0.
- Output stage is free when !out_valid | out_ready. Load occurs only when the stage is free; otherwise out_data, out_ch and out_valid hold, so no sample is dropped or overwritten.
- Manual mode (mode=0):
  - Each free cycle with sel<CHANNELS: out_data<=din[sel], out_ch<=sel, out_valid<=1. Latency is 1 cycle from sel/din to output.
  - sel>=CHANNELS (non-power-of-2 CHANNELS): no load. If the stage is free, out_valid<=0.
  - cnt is held at 0.
- Scan mode (mode=1), FSM states SCAN_DWELL and SCAN_EMIT:
  - SCAN_DWELL: cnt increments each cycle. When cnt==DWELL-1, go to SCAN_EMIT.
  - SCAN_EMIT: if the stage is free, load din[ptr] and ptr, set out_valid=1, advance ptr, set cnt=0, and return to SCAN_DWELL. If the stage is busy, stay in SCAN_EMIT (ptr and cnt frozen).
  - ptr advance: the next set bit of ch_en searched from ptr+1 upward, wrapping CHANNELS-1 -> 0. If ptr is the only enabled channel, ptr is unchanged.
  - If ch_en[ptr]==0 at SCAN_EMIT (mask changed mid-dwell), skip the load, advance ptr as above, set cnt=0.
  - ch_en all zero: no loads; out_valid falls once the pending sample is accepted; ptr holds.
- Mode transitions, effective the cycle after mode changes:
  - manual->scan: ptr<=sel if sel<CHANNELS, else 0; cnt<=0; state SCAN_DWELL.
  - scan->manual: the FSM is abandoned and cnt<=0. A pending unaccepted sample is kept until accepted.
- Sampling instant: din is sampled at the loading edge. Mid-dwell changes on din are not captured.
- Reset mid-operation: all state returns to reset values immediately; the pending sample is discarded.
- With DWELL=1 and out_ready held high, scan emits one sample per 2 cycles (DWELL then EMIT).

Test Plan:
- Manual sweep: CHANNELS=8, WIDTH=8, out_ready=1, din channel k = 8'h10+k, sel stepped 0..7 one per cycle -> out_data=8'h10..8'h17 with out_ch=0..7, each 1 cycle after sel.
- Backpressure: manual, sel=3, out_ready=0 for 5 cycles while din[3] changes each cycle -> out_data frozen at the first captured value, out_valid=1; out_ready=1 -> new value next cycle.
- Scan full mask: mode=1, ch_en=8'hFF, DWELL=4, out_ready=1, sel=0 -> samples from ch 0,1,...,7,0 at 5-cycle intervals; out_ch wraps 7->0.
- Sparse mask: ch_en=8'b1000_0101 -> out_ch sequence 0,2,7,0,2; ch_en=8'b0001_0000 -> out_ch stays 4 every 5 cycles; ch_en=0 -> out_valid drops after the last accept, no further loads.
- Scan stall and mask change: hold out_ready=0 across SCAN_EMIT on ch 2 for 6 cycles -> ptr/cnt frozen, no skip; release -> ch 2 emitted then ch 3. Clear ch_en[3] mid-dwell -> ch 3 skipped, next emitted ch is 4.
- Reset/mode: assert rst_n=0 while out_valid=1 -> all outputs 0 asynchronously. Switch manual(sel=5)->scan -> first scan sample is ch 5 after DWELL+1 cycles.

Source files
------------

// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 multiplexer with a valid/ready output stage.
// Manual mode picks the channel given by sel. Auto-scan mode walks round-robin
// over the enabled channels and spends DWELL cycles on each before sampling.
module mux_scan_nto1 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // The dwell counter needs at least one bit, even when DWELL is 1.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic {
        SCAN_DWELL = 1'b0,
        SCAN_EMIT  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_ch_q, out_ch_d;
    logic                out_valid_q, out_valid_d;

    logic [WIDTH-1:0]    din_arr [CHANNELS];
    logic                stage_free;
    logic                sel_ok;
    logic                ptr_en;
    logic [SEL_W-1:0]    ptr_adv;
    logic                do_load;
    logic [SEL_W-1:0]    load_ch;
    logic [WIDTH-1:0]    load_data;

    // Unpack the flat input bus into one word per channel.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign din_arr[gi] = din[gi*WIDTH +: WIDTH];
    end

    // A select value beyond the last channel is only possible for non-power-of-2 counts.
    assign sel_ok     = 32'(sel) < 32'(CHANNELS);
    assign stage_free = !out_valid_q || out_ready;
    assign ptr_en     = ch_en[ptr_q];

    // Next enabled channel after ptr, wrapping; stays on ptr if no other channel is enabled.
    always_comb begin
        int idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        ptr_adv = ptr_q;
        for (int i = 1; i < CHANNELS; i++) begin
            idx = (int'(ptr_q) + i) % CHANNELS;
            if (!found && ch_en[idx]) begin
                ptr_adv = SEL_W'(idx);
                found   = 1'b1;
            end
        end
    end

    // Select the word of the channel being loaded.
    always_comb begin
        load_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (SEL_W'(k) == load_ch) begin
                load_data = din_arr[k];
            end
        end
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN_DWELL;
            ptr_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Scan FSM next state; manual mode parks the FSM in SCAN_DWELL so scanning
    // starts with a full dwell as soon as mode goes high.
    always_comb begin
        state_d = state_q;
        if (!mode) begin
            state_d = SCAN_DWELL;
        end else begin
            case (state_q)
                SCAN_DWELL: if (cnt_q == CNT_LAST) state_d = SCAN_EMIT;
                SCAN_EMIT:  if (!ptr_en || stage_free) state_d = SCAN_DWELL;
                default:    state_d = SCAN_DWELL;
            endcase
        end
    end

    // FSM outputs: load request, pointer and dwell counter updates.
    // In manual mode ptr follows sel so a switch to scan starts on the selected channel.
    always_comb begin
        do_load = 1'b0;
        load_ch = ptr_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!mode) begin
            cnt_d   = '0;
            ptr_d   = sel_ok ? sel : '0;
            do_load = sel_ok;
            load_ch = sel;
        end else begin
            case (state_q)
                SCAN_DWELL: begin
                    if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
                end
                SCAN_EMIT: begin
                    // A channel disabled during the dwell is skipped without waiting for the stage.
                    if (!ptr_en) begin
                        ptr_d = ptr_adv;
                        cnt_d = '0;
                    end else if (stage_free) begin
                        do_load = 1'b1;
                        ptr_d   = ptr_adv;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output stage: only changes when free; a free stage with nothing to load empties.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (stage_free) begin
            if (do_load) begin
                out_data_d  = load_data;
                out_ch_d    = load_ch;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Testbench for mux_scan_nto1: table-driven manual checks, directed scan
// sequences and a randomized run against a behavioural reference model.
module tb_mux_scan_nto1;

    localparam int W  = 8;
    localparam int CH = 8;
    localparam int SW = 3;
    localparam int DW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              mode = 1'b0;
    logic [SW-1:0]     sel = '0;
    logic [CH-1:0]     ch_en = '1;
    logic [CH*W-1:0]   din = '0;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_ch;
    logic              out_valid;
    logic              out_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [W-1:0] m_data;
    int           m_ch;
    bit           m_valid;
    int           m_ptr;
    int           m_wait;   // dwell cycles still to spend before the current channel is due

    mux_scan_nto1 #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .ch_en(ch_en), .din(din),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int next_ch(input int p, input logic [CH-1:0] en);
        for (int i = 1; i < CH; i++) begin
            if (en[(p + i) % CH]) return (p + i) % CH;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_data = '0; m_ch = 0; m_valid = 0; m_ptr = 0; m_wait = DW;
    endtask

    // One clock edge of the specified behaviour, using the inputs present before the edge.
    task automatic model_step();
        bit free;
        int s;
        free = !m_valid || out_ready;
        s = int'(sel);
        if (!mode) begin
            m_wait = DW;
            m_ptr  = (s < CH) ? s : 0;
            if (free) begin
                if (s < CH) begin
                    m_data = din[s*W +: W]; m_ch = s; m_valid = 1;
                end else m_valid = 0;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (free) m_valid = 0;
        end else if (!ch_en[m_ptr]) begin
            m_ptr  = next_ch(m_ptr, ch_en);
            m_wait = DW;
            if (free) m_valid = 0;
        end else if (free) begin
            m_data = din[m_ptr*W +: W]; m_ch = m_ptr; m_valid = 1;
            m_ptr  = next_ch(m_ptr, ch_en);
            m_wait = DW;
        end
    endtask

    task automatic cmp_model();
        chk("model_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("model_data", 32'(out_data), 32'(m_data));
            chk("model_ch", 32'(out_ch), 32'(m_ch));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ch", 32'(out_ch), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_ramp(input logic [W-1:0] base);
        for (int k = 0; k < CH; k++) din[k*W +: W] = base + W'(k);
    endtask

    // Tick until out_valid, at most budget edges; n returns the number of edges taken.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < budget);
        if (!out_valid) begin
            chk("wait_valid_timeout", 32'(n), 32'(budget + 1));
        end else begin
            $display("sample ch=%0d data=%02h after %0d cycles", out_ch, out_data, n);
        end
    endtask

    typedef struct {
        logic [SW-1:0] sel;
        logic          rdy;
        logic [W-1:0]  d3;
        logic [W-1:0]  exp_data;
        logic [SW-1:0] exp_ch;
        logic          exp_valid;
    } vec_t;

    initial begin
        vec_t vt[$];
        int n;
        int vcount;
        int exp_seq[5];

        // ---------------- reset state + manual table ----------------
        mode = 0; ch_en = '1; out_ready = 1; set_ramp(8'h10);
        do_reset();
        for (int k = 0; k < CH; k++)
            vt.push_back('{sel: SW'(k), rdy: 1'b1, d3: 8'h13, exp_data: 8'h10 + W'(k), exp_ch: SW'(k), exp_valid: 1'b1});
        vt.push_back('{sel: 3'd3, rdy: 1'b1, d3: 8'h13, exp_data: 8'h13, exp_ch: 3'd3, exp_valid: 1'b1});
        for (int k = 0; k < 5; k++)
            vt.push_back('{sel: 3'd3, rdy: 1'b0, d3: 8'h50 + W'(k), exp_data: 8'h13, exp_ch: 3'd3, exp_valid: 1'b1});
        vt.push_back('{sel: 3'd3, rdy: 1'b1, d3: 8'h55, exp_data: 8'h55, exp_ch: 3'd3, exp_valid: 1'b1});
        foreach (vt[i]) begin
            sel = vt[i].sel; out_ready = vt[i].rdy; din[3*W +: W] = vt[i].d3;
            tick();
            $display("manual sel=%0d rdy=%0d -> valid=%0d ch=%0d data=%02h", sel, out_ready, out_valid, out_ch, out_data);
            chk("tbl_valid", 32'(out_valid), 32'(vt[i].exp_valid));
            chk("tbl_data", 32'(out_data), 32'(vt[i].exp_data));
            chk("tbl_ch", 32'(out_ch), 32'(vt[i].exp_ch));
        end

        // ---------------- scan, full mask ----------------
        mode = 1; sel = 0; ch_en = 8'hFF; out_ready = 1; set_ramp(8'h20);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wait_valid(12, n);
            chk("full_ch", 32'(out_ch), 32'(i % CH));
            chk("full_data", 32'(out_data), 32'h20 + 32'(i % CH));
            chk("full_interval", 32'(n), 32'(DW + 1));
        end

        // ---------------- scan, sparse masks ----------------
        ch_en = 8'b1000_0101;
        do_reset();
        exp_seq = '{0, 2, 7, 0, 2};
        for (int i = 0; i < 5; i++) begin
            wait_valid(12, n);
            chk("sparse_ch", 32'(out_ch), 32'(exp_seq[i]));
            chk("sparse_interval", 32'(n), 32'(DW + 1));
        end
        ch_en = 8'b0001_0000;
        wait_valid(20, n);
        chk("single_first_ch", 32'(out_ch), 32'd4);
        chk("single_first_interval", 32'(n), 32'(2 * (DW + 1)));
        for (int i = 0; i < 2; i++) begin
            wait_valid(12, n);
            chk("single_ch", 32'(out_ch), 32'd4);
            chk("single_interval", 32'(n), 32'(DW + 1));
        end
        ch_en = '0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) vcount++;
        end
        chk("empty_mask_no_loads", 32'(vcount), 32'd0);

        // ---------------- scan stall across EMIT ----------------
        mode = 0; sel = 2; ch_en = 8'hFF; out_ready = 1; set_ramp(8'h30);
        do_reset();
        tick();
        chk("stall_manual_data", 32'(out_data), 32'h32);
        mode = 1; out_ready = 0; din[2*W +: W] = 8'h42;
        for (int i = 0; i < DW + 6; i++) begin
            tick();
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_data", 32'(out_data), 32'h32);
        end
        out_ready = 1;
        tick();
        chk("stall_release_ch", 32'(out_ch), 32'd2);
        chk("stall_release_data", 32'(out_data), 32'h42);
        wait_valid(12, n);
        chk("stall_next_ch", 32'(out_ch), 32'd3);
        chk("stall_next_interval", 32'(n), 32'(DW + 1));

        // ---------------- mask change mid-dwell ----------------
        mode = 0; sel = 2; ch_en = 8'hFF; out_ready = 1; set_ramp(8'h30);
        do_reset();
        tick();
        mode = 1;
        wait_valid(12, n);
        chk("skip_first_ch", 32'(out_ch), 32'd2);
        tick(); tick();
        ch_en = 8'hF7;
        wait_valid(20, n);
        chk("skip_ch", 32'(out_ch), 32'd4);
        chk("skip_interval", 32'(n), 32'd8);

        // ---------------- manual(sel=5) -> scan, then reset mid-sample ----------------
        mode = 0; sel = 5; ch_en = 8'hFF; out_ready = 1; set_ramp(8'h60);
        do_reset();
        tick();
        chk("m2s_manual_ch", 32'(out_ch), 32'd5);
        mode = 1;
        wait_valid(12, n);
        chk("m2s_ch", 32'(out_ch), 32'd5);
        chk("m2s_data", 32'(out_data), 32'h65);
        chk("m2s_latency", 32'(n), 32'(DW + 1));
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        do_reset();

        // ---------------- randomized run against the model ----------------
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 63) == 0) mode = ~mode;
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 3))
                    0: ch_en = '0;
                    1: ch_en = CH'(1) << $urandom_range(0, CH - 1);
                    default: ch_en = CH'($urandom);
                endcase
            end
            sel = SW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            din = {$urandom, $urandom};
            if ($urandom_range(0, 799) == 0) do_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
